// File: rtl/composer_pkg.sv
// Shared constants and types for the composer step-sequencer blocks.
// Pattern geometry, the rest-note code and the sequencer state encoding.
package composer_pkg;
    localparam int STEPS  = 32;
    localparam int NOTE_W = 5;
    localparam int STEP_W = 5;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // A tempo of zero would never reach a step boundary, so it runs as one tick per step.
    function automatic logic [3:0] eff_tempo_f(input logic [3:0] t);
        return (t == 4'd0) ? 4'd1 : t;
    endfunction
endpackage

// File: rtl/tick_sync.sv
// Synchronises a slow level into clk and emits a one-cycle strobe per rising edge.
// Latency: strobe is high for the cycle ending on the third clk edge after the input rises.
// Backpressure: none; every rising edge that survives synchronisation yields one strobe.
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic strobe
);
    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign strobe = sync2 & ~prev;
endmodule

// File: rtl/note_sequencer.sv
// Steps through a note pattern on synchronised 16 Hz ticks and drives note/gate.
// Latency: note/gate/step_pulse update on the edge that samples the tick strobe.
// Backpressure: none; strobes coinciding with clear_pos or play=0 are dropped.
module note_sequencer
    import composer_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              tick_16hz,
    input  logic              play,
    input  logic              clear_pos,
    input  logic [3:0]        tempo,
    input  logic              wr_en,
    input  logic [STEP_W-1:0] wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    output logic [NOTE_W-1:0] note,
    output logic              gate,
    output logic [STEP_W-1:0] step,
    output logic              step_pulse,
    output logic              playing
);
    logic              strobe;
    state_t            state;
    logic [3:0]        tick_cnt;
    logic [3:0]        eff_tempo;
    logic [NOTE_W-1:0] pattern [STEPS];
    logic [STEP_W-1:0] load_idx;
    logic [NOTE_W-1:0] load_note;
    logic              boundary;
    logic              do_load;
    logic [3:0]        tick_nxt;
    logic [3:0]        last_tick;

    tick_sync u_tick_sync (
        .clk      (CLOCK_50),
        .rst_n    (resetn),
        .async_in (tick_16hz),
        .strobe   (strobe)
    );

    assign tick_nxt  = tick_cnt + 4'd1;
    assign last_tick = eff_tempo - 4'd1;

    // The first load out of IDLE replays the held step; later loads advance it.
    assign load_idx  = (state == IDLE) ? step : step + STEP_W'(1);
    assign load_note = pattern[load_idx];

    assign boundary = (state == IDLE)
                   || (state == GATE    && eff_tempo == 4'd1)
                   || (state == RELEASE && tick_cnt == last_tick);
    assign do_load  = strobe && play && !clear_pos && boundary;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            tick_cnt   <= 4'd0;
            eff_tempo  <= 4'd1;
            note       <= NOTE_REST;
            gate       <= 1'b0;
            step       <= '0;
            step_pulse <= 1'b0;
            playing    <= 1'b0;
            for (int i = 0; i < STEPS; i++) pattern[i] <= NOTE_REST;
        end else begin
            step_pulse <= 1'b0;
            // Written after the read above has been sampled, so a same-edge write is seen next visit.
            if (wr_en) pattern[wr_addr] <= wr_note;

            if (clear_pos) begin
                state    <= IDLE;
                step     <= '0;
                tick_cnt <= 4'd0;
                gate     <= 1'b0;
                note     <= NOTE_REST;
                playing  <= 1'b0;
            end else if (!play) begin
                state    <= IDLE;
                tick_cnt <= 4'd0;
                gate     <= 1'b0;
                note     <= NOTE_REST;
                playing  <= 1'b0;
            end else if (do_load) begin
                state      <= GATE;
                step       <= load_idx;
                note       <= load_note;
                gate       <= (load_note != NOTE_REST);
                eff_tempo  <= eff_tempo_f(tempo);
                tick_cnt   <= 4'd0;
                step_pulse <= 1'b1;
                playing    <= 1'b1;
            end else if (strobe && state == GATE) begin
                tick_cnt <= tick_nxt;
                if (tick_nxt == last_tick) begin
                    gate  <= 1'b0;
                    state <= RELEASE;
                end
            end
        end
    end
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus randomized ticks
// checked against a tick-counting model of the step/gate rules.
module tb_note_sequencer;
    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       tick_16hz;
    logic       play;
    logic       clear_pos;
    logic [3:0] tempo;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [4:0] wr_note;
    logic [4:0] note;
    logic       gate;
    logic [4:0] step;
    logic       step_pulse;
    logic       playing;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: running flag, step index, ticks into the step, latched step length, current note.
    bit m_run;
    int m_step, m_k, m_n, m_note;
    int m_pat [32];

    note_sequencer dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .tick_16hz  (tick_16hz),
        .play       (play),
        .clear_pos  (clear_pos),
        .tempo      (tempo),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_note    (wr_note),
        .note       (note),
        .gate       (gate),
        .step       (step),
        .step_pulse (step_pulse),
        .playing    (playing)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic int exp_note();
        return m_run ? m_note : 0;
    endfunction

    function automatic bit exp_gate();
        return m_run && (m_note != 0) && (m_n == 1 || m_k < m_n - 1);
    endfunction

    function automatic int len_of(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic model_reset();
        m_run = 0; m_step = 0; m_k = 0; m_n = 1; m_note = 0;
        for (int i = 0; i < 32; i++) m_pat[i] = 0;
    endtask

    task automatic write_pat(input int a, input int d);
        @(negedge CLOCK_50);
        wr_en = 1'b1; wr_addr = 5'(a); wr_note = 5'(d);
        @(posedge CLOCK_50); #1;
        wr_en = 1'b0;
        m_pat[a] = d;
    endtask

    // One tick of the 16 Hz input; optional clear/pause/write land on the edge that takes the strobe.
    task automatic do_tick(input bit clr, input bit drop, input bit wr, input int wa, input int wd);
        bit exp_pulse;
        @(negedge CLOCK_50);
        tick_16hz = 1'b1;
        @(posedge CLOCK_50); @(posedge CLOCK_50); #1;
        n_checks++;
        if (step_pulse !== 1'b0) begin
            n_fail++; $display("FAIL early_pulse: step_pulse=%0b required 0", step_pulse);
        end
        @(negedge CLOCK_50);
        if (clr) clear_pos = 1'b1;
        if (drop) play = 1'b0;
        if (wr) begin wr_en = 1'b1; wr_addr = 5'(wa); wr_note = 5'(wd); end
        exp_pulse = 0;
        if (clr) begin
            m_step = 0; m_run = 0; m_k = 0;
        end else if (!play) begin
            m_run = 0; m_k = 0;
        end else if (!m_run) begin
            m_run = 1; m_k = 0; m_n = len_of(int'(tempo)); m_note = m_pat[m_step]; exp_pulse = 1;
        end else begin
            m_k++;
            if (m_k >= m_n) begin
                m_step = (m_step + 1) % 32; m_k = 0; m_n = len_of(int'(tempo));
                m_note = m_pat[m_step]; exp_pulse = 1;
            end
        end
        if (wr) m_pat[wa] = wd;
        @(posedge CLOCK_50); #1;
        clear_pos = 1'b0; wr_en = 1'b0; tick_16hz = 1'b0;
        if (drop) play = 1'b1;
        n_checks++;
        if (step_pulse !== exp_pulse) begin
            n_fail++; $display("FAIL tick_pulse: step_pulse=%0b required %0b", step_pulse, exp_pulse);
        end
        n_checks++;
        if (step !== 5'(m_step)) begin
            n_fail++; $display("FAIL tick_step: step=%0d required %0d", step, m_step);
        end
        n_checks++;
        if (note !== 5'(exp_note())) begin
            n_fail++; $display("FAIL tick_note: note=%0d required %0d (step %0d)", note, exp_note(), m_step);
        end
        n_checks++;
        if (gate !== exp_gate()) begin
            n_fail++; $display("FAIL tick_gate: gate=%0b required %0b (step %0d k %0d n %0d)",
                               gate, exp_gate(), m_step, m_k, m_n);
        end
        n_checks++;
        if (playing !== m_run) begin
            n_fail++; $display("FAIL tick_playing: playing=%0b required %0b", playing, m_run);
        end
        @(posedge CLOCK_50); #1;
        n_checks++;
        if (step_pulse !== 1'b0) begin
            n_fail++; $display("FAIL pulse_width: step_pulse=%0b required 0", step_pulse);
        end
        repeat (3) @(posedge CLOCK_50);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({note, gate, step, step_pulse, playing} !== 13'd0) begin
            n_fail++; $display("FAIL reset_outputs: note=%0d gate=%0b step=%0d pulse=%0b playing=%0b required all 0",
                               note, gate, step, step_pulse, playing);
        end
    endtask

    task automatic test_basic();
        write_pat(0, 5); write_pat(1, 0); write_pat(2, 12); write_pat(4, 2);
        tempo = 4'd4; play = 1'b1;
        do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd0 || note !== 5'd5 || gate !== 1'b1) begin
            n_fail++; $display("FAIL basic_first: step=%0d note=%0d gate=%0b required 0/5/1", step, note, gate);
        end
        repeat (3) do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (gate !== 1'b0 || note !== 5'd5) begin
            n_fail++; $display("FAIL basic_release: gate=%0b note=%0d required 0/5", gate, note);
        end
        do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd1 || note !== 5'd0 || gate !== 1'b0) begin
            n_fail++; $display("FAIL basic_rest: step=%0d note=%0d gate=%0b required 1/0/0", step, note, gate);
        end
        repeat (4) do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd2 || note !== 5'd12 || gate !== 1'b1) begin
            n_fail++; $display("FAIL basic_step2: step=%0d note=%0d gate=%0b required 2/12/1", step, note, gate);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (!(m_step == 31 && m_k == m_n - 1) && guard < 300) begin
            do_tick(0, 0, 0, 0, 0); guard++;
        end
        n_checks++;
        if (guard >= 300) begin n_fail++; $display("FAIL wrap_timeout: guard=%0d required <300", guard); end
        do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd0 || note !== 5'd5) begin
            n_fail++; $display("FAIL wrap_step0: step=%0d note=%0d required 0/5", step, note);
        end
    endtask

    task automatic test_pause();
        int guard = 0;
        write_pat(3, 7);
        while (!(m_step == 3 && m_k == 0 && m_run) && guard < 300) begin
            do_tick(0, 0, 0, 0, 0); guard++;
        end
        n_checks++;
        if (guard >= 300) begin n_fail++; $display("FAIL pause_timeout: guard=%0d required <300", guard); end
        @(negedge CLOCK_50); play = 1'b0;
        @(posedge CLOCK_50); #1;
        m_run = 0; m_k = 0;
        n_checks++;
        if (gate !== 1'b0 || note !== 5'd0 || playing !== 1'b0 || step !== 5'd3) begin
            n_fail++; $display("FAIL pause_state: gate=%0b note=%0d playing=%0b step=%0d required 0/0/0/3",
                               gate, note, playing, step);
        end
        @(negedge CLOCK_50); play = 1'b1;
        do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd3 || note !== 5'd7 || gate !== 1'b1) begin
            n_fail++; $display("FAIL pause_resume: step=%0d note=%0d gate=%0b required 3/7/1", step, note, gate);
        end
    endtask

    task automatic test_clear();
        int guard = 0;
        while (!(m_step == 7 && m_run) && guard < 300) begin
            do_tick(0, 0, 0, 0, 0); guard++;
        end
        n_checks++;
        if (guard >= 300) begin n_fail++; $display("FAIL clear_timeout: guard=%0d required <300", guard); end
        do_tick(1, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd0 || playing !== 1'b0 || gate !== 1'b0) begin
            n_fail++; $display("FAIL clear_state: step=%0d playing=%0b gate=%0b required 0/0/0", step, playing, gate);
        end
        do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd0 || note !== 5'd5 || playing !== 1'b1) begin
            n_fail++; $display("FAIL clear_replay: step=%0d note=%0d playing=%0b required 0/5/1", step, note, playing);
        end
    endtask

    task automatic test_collision();
        int guard = 0;
        while (!(m_step == 3 && m_k == m_n - 1 && m_run) && guard < 300) begin
            do_tick(0, 0, 0, 0, 0); guard++;
        end
        n_checks++;
        if (guard >= 300) begin n_fail++; $display("FAIL coll_timeout: guard=%0d required <300", guard); end
        do_tick(0, 0, 1, 4, 9);
        n_checks++;
        if (step !== 5'd4 || note !== 5'd2) begin
            n_fail++; $display("FAIL coll_old: step=%0d note=%0d required 4/2", step, note);
        end
        tempo = 4'd0;
        guard = 0;
        while (!(m_step == 3 && m_n == 1) && guard < 300) begin
            do_tick(0, 0, 0, 0, 0); guard++;
        end
        do_tick(0, 0, 0, 0, 0);
        n_checks++;
        if (step !== 5'd4 || note !== 5'd9 || gate !== 1'b1) begin
            n_fail++; $display("FAIL coll_new: step=%0d note=%0d gate=%0b required 4/9/1", step, note, gate);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            bit clr, drop, wr;
            if ($urandom_range(0, 3) == 0) tempo = 4'($urandom_range(0, 5));
            clr  = ($urandom_range(0, 19) == 0);
            drop = ($urandom_range(0, 19) == 0);
            wr   = ($urandom_range(0, 2) == 0);
            do_tick(clr, drop, wr, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        tempo = 4'd3;
        while (!(m_run && gate === 1'b1) && guard < 100) begin
            do_tick(0, 0, 0, 0, 0); guard++;
        end
        @(negedge CLOCK_50); #3;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({note, gate, step, step_pulse, playing} !== 13'd0) begin
            n_fail++; $display("FAIL async_reset: note=%0d gate=%0b step=%0d pulse=%0b playing=%0b required all 0",
                               note, gate, step, step_pulse, playing);
        end
        model_reset();
        @(negedge CLOCK_50); resetn = 1'b1;
        tempo = 4'd0;
        for (int i = 0; i < 6; i++) begin
            do_tick(0, 0, 0, 0, 0);
            n_checks++;
            if (note !== 5'd0 || gate !== 1'b0) begin
                n_fail++; $display("FAIL reset_pattern: step=%0d note=%0d gate=%0b required note 0 gate 0",
                                   step, note, gate);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; tick_16hz = 1'b0; play = 1'b0; clear_pos = 1'b0;
        tempo = 4'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_note = 5'd0;
        model_reset();
        repeat (3) @(posedge CLOCK_50);
        test_reset();
        @(negedge CLOCK_50); resetn = 1'b1;
        test_basic();
        test_wrap();
        test_pause();
        test_clear();
        test_collision();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
